// File: rtl/nrs_pkg.sv
// Shared types and helpers for the NRS least-squares estimator.
// FSM encoding, default slot depth and QPSK sign mapping.
package nrs_pkg;

  localparam int N_NRS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    ACK
  } nrs_state_e;

  function automatic logic signed [1:0] qpsk_sign(input logic b);
    return b ? 2'sb11 : 2'sb01;
  endfunction

endpackage

// File: rtl/nrs_ls_estimator_if.sv
// Received-RE stream from the demapper into the estimator.
// Valid/ready handshake with signed I/Q payload.
interface nrs_ls_estimator_if #(
  parameter int WIDTH_IQ = 16
);

  logic                       re_valid;
  logic                       re_ready;
  logic signed [WIDTH_IQ-1:0] re_i;
  logic signed [WIDTH_IQ-1:0] re_q;

  modport master (
    output re_valid,
    output re_i,
    output re_q,
    input  re_ready
  );

  modport slave (
    input  re_valid,
    input  re_i,
    input  re_q,
    output re_ready
  );

endinterface

// File: rtl/nrs_conj_mult.sv
// Y*conj(X) for a QPSK reference X; X has unit-magnitude I/Q,
// so the product reduces to sign flips and two adds.
module nrs_conj_mult
  import nrs_pkg::*;
#(
  parameter int WIDTH_IQ = 16
) (
  input  logic signed [WIDTH_IQ-1:0] y_i,
  input  logic signed [WIDTH_IQ-1:0] y_q,
  input  logic                       x_r,
  input  logic                       x_i,
  output logic signed [WIDTH_IQ:0]   h_i,
  output logic signed [WIDTH_IQ:0]   h_q
);

  logic signed [1:0]        sr;
  logic signed [1:0]        si;
  logic signed [WIDTH_IQ:0] e_i;
  logic signed [WIDTH_IQ:0] e_q;
  logic signed [WIDTH_IQ:0] sr_i;
  logic signed [WIDTH_IQ:0] sr_q;
  logic signed [WIDTH_IQ:0] si_i;
  logic signed [WIDTH_IQ:0] si_q;

  assign sr  = qpsk_sign(x_r);
  assign si  = qpsk_sign(x_i);
  assign e_i = {y_i[WIDTH_IQ-1], y_i};
  assign e_q = {y_q[WIDTH_IQ-1], y_q};

  assign sr_i = sr[1] ? -e_i : e_i;
  assign sr_q = sr[1] ? -e_q : e_q;
  assign si_i = si[1] ? -e_i : e_i;
  assign si_q = si[1] ? -e_q : e_q;

  assign h_i = sr_i + si_q;
  assign h_q = sr_q - si_i;

endmodule

// File: rtl/nrs_ls_estimator.sv
// LS channel estimator on NRS REs: H = Y*conj(X), est_ack per slot.
// Optional slot average of H enabled by NRS_LS_AVG_EN.
module nrs_ls_estimator
  import nrs_pkg::*;
#(
  parameter int WIDTH_IQ = 16,
  parameter int N_NRS    = N_NRS_DEFAULT,
  parameter int LINES    = $clog2(N_NRS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_frame,
  input  logic                     NRS_gen_ready,
  nrs_ls_estimator_if.slave        re_bus,
  output logic [LINES-1:0]         rd_addr_est,
  input  logic                     nrs_est_r,
  input  logic                     nrs_est_i,
  output logic                     h_valid,
  output logic signed [WIDTH_IQ:0] h_i,
  output logic signed [WIDTH_IQ:0] h_q,
  output logic [LINES-1:0]         h_idx,
  output logic                     est_ack
`ifdef NRS_LS_AVG_EN
  ,
  output logic                     h_avg_valid,
  output logic signed [WIDTH_IQ:0] h_avg_i,
  output logic signed [WIDTH_IQ:0] h_avg_q
`endif
);

  localparam logic [LINES-1:0] K_LAST = LINES'(N_NRS - 1);

  nrs_state_e                 state_q;
  nrs_state_e                 state_d;
  logic [LINES-1:0]           k_q;
  logic [LINES-1:0]           k_d;
  logic                       re_ready;
  logic                       accept;
  logic signed [WIDTH_IQ-1:0] y_i;
  logic signed [WIDTH_IQ-1:0] y_q;
  logic signed [WIDTH_IQ:0]   p_i;
  logic signed [WIDTH_IQ:0]   p_q;

  assign y_i             = re_bus.re_i;
  assign y_q             = re_bus.re_q;
  assign re_bus.re_ready = re_ready;
  assign rd_addr_est     = k_q;

  nrs_conj_mult #(
    .WIDTH_IQ(WIDTH_IQ)
  ) u_mult (
    .y_i(y_i),
    .y_q(y_q),
    .x_r(nrs_est_r),
    .x_i(nrs_est_i),
    .h_i(p_i),
    .h_q(p_q)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    re_ready = 1'b0;
    accept   = 1'b0;
    est_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (NRS_gen_ready) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        re_ready = 1'b1;
        accept   = re_bus.re_valid & ~new_frame;
        if (accept) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            k_d     = '0;
          end else begin
            k_d = k_q + LINES'(1);
          end
        end
      end
      DRAIN: state_d = ACK;
      ACK: begin
        est_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every state; the slot is never acknowledged.
    if (new_frame) begin
      state_d = IDLE;
      k_d     = '0;
      est_ack = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      h_valid <= 1'b0;
      h_i     <= '0;
      h_q     <= '0;
      h_idx   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      h_valid <= accept;
      if (accept) begin
        h_i   <= p_i;
        h_q   <= p_q;
        h_idx <= k_q;
      end
    end
  end

`ifdef NRS_LS_AVG_EN
  localparam int AW = WIDTH_IQ + 1 + LINES;

  logic signed [AW-1:0] acc_i_q;
  logic signed [AW-1:0] acc_q_q;
  logic                 avg_unused;

  always_ff @(posedge clk) begin
    if (rst || new_frame || state_q == ACK) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else if (accept) begin
      acc_i_q <= acc_i_q + AW'(p_i);
      acc_q_q <= acc_q_q + AW'(p_q);
    end
  end

  // Dropping the low LINES bits is the arithmetic shift by LINES.
  assign avg_unused  = ^{acc_i_q[LINES-1:0], acc_q_q[LINES-1:0]};
  assign h_avg_valid = est_ack;
  assign h_avg_i     = est_ack ? acc_i_q[AW-1:LINES] : '0;
  assign h_avg_q     = est_ack ? acc_q_q[AW-1:LINES] : '0;
`endif

endmodule
